// File: rtl/ofifo_col_align_pkg.sv
// Shared constants and helpers for the array-side FIFOs (output column aligner and input row FIFO).
package ofifo_col_align_pkg;

  localparam int unsigned DefCol   = 8;
  localparam int unsigned DefBw    = 16;
  localparam int unsigned DefDepth = 16;

  // One extra MSB over the address lets all depth entries be used.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned row_width(input int unsigned col, input int unsigned bw);
    return col * bw;
  endfunction

endpackage

// File: rtl/ofifo_col_align_lane_fifo.sv
// Single-lane FIFO with a combinational head entry; one instance per array column.
module ofifo_col_align_lane_fifo
  import ofifo_col_align_pkg::*;
#(
  parameter int unsigned bw    = DefBw,
  parameter int unsigned depth = DefDepth
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [bw-1:0] din,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [bw-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PtrW  = ptr_width(depth);
  localparam int unsigned AddrW = PtrW - 1;

  logic [bw-1:0]   mem [depth];
  logic [PtrW-1:0] wp_q, wp_d;
  logic [PtrW-1:0] rp_q, rp_d;
  logic            wr_ok;
  logic            rd_ok;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AddrW-1:0] == rp_q[AddrW-1:0]) && (wp_q[AddrW] != rp_q[AddrW]);
  assign dout  = mem[rp_q[AddrW-1:0]];

  // Full is judged before any same-cycle read, so there is no write pass-through.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (wr_ok) wp_d = wp_q + PtrW'(1);
    if (rd_ok) rp_d = rp_q + PtrW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp_q[AddrW-1:0]] <= din;
  end

endmodule

// File: rtl/ofifo_col_align.sv
// Output FIFO of the MAC array: columns write independently, reader pops one aligned row.
module ofifo_col_align
  import ofifo_col_align_pkg::*;
#(
  parameter int unsigned col   = DefCol,
  parameter int unsigned bw    = DefBw,
  parameter int unsigned depth = DefDepth
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [row_width(col, bw)-1:0]  in,
  input  logic [col-1:0]                 wr,
  input  logic                           rd,
  output logic [row_width(col, bw)-1:0]  out,
  output logic                           o_out_valid,
  output logic                           o_valid,
  output logic                           o_full,
  output logic                           o_overflow
);

  localparam int unsigned RowW = row_width(col, bw);

  logic [RowW-1:0] head_row;
  logic [col-1:0]  full_v;
  logic [col-1:0]  empty_v;
  logic            rd_ok;

  logic [RowW-1:0] out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            ovf_q, ovf_d;

  assign o_valid = &(~empty_v);
  assign o_full  = |full_v;
  assign rd_ok   = rd && o_valid;

  for (genvar c = 0; c < col; c++) begin : g_lane
    ofifo_col_align_lane_fifo #(
      .bw    (bw),
      .depth (depth)
    ) u_lane_fifo (
      .clk   (clk),
      .reset (reset),
      .din   (in[bw*c +: bw]),
      .wr_en (wr[c]),
      .rd_en (rd_ok),
      .dout  (head_row[bw*c +: bw]),
      .full  (full_v[c]),
      .empty (empty_v[c])
    );
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = rd_ok;
    ovf_d       = ovf_q || |(wr & full_v);
    if (rd_ok) out_d = head_row;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out         = out_q;
  assign o_out_valid = out_valid_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_ofifo_col_align.sv
// Self-checking bench: per-lane reference model with a scoreboard of expected rows.
module tb_ofifo_col_align;

  localparam int Col   = 8;
  localparam int Bw    = 16;
  localparam int Depth = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [Col*Bw-1:0] in = '0;
  logic [Col-1:0]   wr = '0;
  logic             rd = 1'b0;
  logic [Col*Bw-1:0] out;
  logic             o_out_valid, o_valid, o_full, o_overflow;

  ofifo_col_align #(
    .col   (Col),
    .bw    (Bw),
    .depth (Depth)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .wr          (wr),
    .rd          (rd),
    .out         (out),
    .o_out_valid (o_out_valid),
    .o_valid     (o_valid),
    .o_full      (o_full),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int rows_out = 0;

  // Reference model: per-lane circular store with head/count.
  logic [Bw-1:0]     mm [Col][Depth];
  int                hd [Col];
  int                cnt [Col];
  logic              ov_m;
  logic [Col*Bw-1:0] last_out;
  logic [Col*Bw-1:0] exp_q [$];

  task automatic check(input string name, input logic [Col*Bw-1:0] act,
                       input logic [Col*Bw-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic m_valid();
    logic v = 1'b1;
    for (int c = 0; c < Col; c++) if (cnt[c] == 0) v = 1'b0;
    return v;
  endfunction

  function automatic logic m_full();
    logic f = 1'b0;
    for (int c = 0; c < Col; c++) if (cnt[c] == Depth) f = 1'b1;
    return f;
  endfunction

  function automatic logic [Col*Bw-1:0] fill(input logic [Bw-1:0] v);
    logic [Col*Bw-1:0] r;
    for (int c = 0; c < Col; c++) r[Bw*c +: Bw] = v;
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < Col; c++) begin
      hd[c]  = 0;
      cnt[c] = 0;
    end
    ov_m = 1'b0;
    last_out = '0;
    exp_q.delete();
  endtask

  // Drive one cycle, advance the model, then compare all outputs #1 after the edge.
  task automatic cyc(input logic [Col-1:0] w, input logic [Col*Bw-1:0] d, input logic r,
                     input logic rst);
    logic              acc;
    logic              full_pre [Col];
    logic [Col*Bw-1:0] row;
    acc = 1'b0;
    for (int c = 0; c < Col; c++) full_pre[c] = (cnt[c] == Depth);
    wr = w; in = d; rd = r; reset = rst;
    acc = r && m_valid() && !rst;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (acc) begin
        for (int c = 0; c < Col; c++) begin
          row[Bw*c +: Bw] = mm[c][hd[c]];
          hd[c] = (hd[c] + 1) % Depth;
          cnt[c]--;
        end
        exp_q.push_back(row);
      end
      for (int c = 0; c < Col; c++) begin
        if (w[c]) begin
          if (full_pre[c]) ov_m = 1'b1;
          else begin
            mm[c][(hd[c] + cnt[c]) % Depth] = d[Bw*c +: Bw];
            cnt[c]++;
          end
        end
      end
    end
    #1;
    check("o_out_valid", {127'b0, o_out_valid}, {127'b0, acc});
    if (o_out_valid) begin
      if (exp_q.size() == 0) check("out_unexpected", out, last_out);
      else begin
        row = exp_q.pop_front();
        check("out_row", out, row);
        last_out = row;
        rows_out++;
      end
    end else begin
      check("out_hold", out, last_out);
    end
    check("o_valid", {127'b0, o_valid}, {127'b0, m_valid()});
    check("o_full", {127'b0, o_full}, {127'b0, m_full()});
    check("o_overflow", {127'b0, o_overflow}, {127'b0, ov_m});
    wr = '0; rd = 1'b0; reset = 1'b0;
  endtask

  typedef struct {
    logic [Col-1:0] wr;
    logic           rd;
    logic           ev;
    logic           ef;
    logic           eov;
    logic           eo;
  } vec_t;

  vec_t              tbl [6];
  logic [Col*Bw-1:0] lane_c;
  int                guard;

  initial begin
    model_clear();
    for (int c = 0; c < Col; c++) lane_c[Bw*c +: Bw] = 16'h0C00 + 16'(c);

    // Reset, idle, then partial rows that must not be readable until lane 7 arrives.
    cyc('0, '0, 1'b0, 1'b1);
    cyc('0, '0, 1'b0, 1'b1);
    check("reset_out", out, '0);
    tbl[0] = '{wr: 8'h00, rd: 1'b1, ev: 1'b0, ef: 1'b0, eov: 1'b0, eo: 1'b0};
    tbl[1] = '{wr: 8'h7F, rd: 1'b0, ev: 1'b0, ef: 1'b0, eov: 1'b0, eo: 1'b0};
    tbl[2] = '{wr: 8'h00, rd: 1'b1, ev: 1'b0, ef: 1'b0, eov: 1'b0, eo: 1'b0};
    tbl[3] = '{wr: 8'h80, rd: 1'b0, ev: 1'b1, ef: 1'b0, eov: 1'b0, eo: 1'b0};
    tbl[4] = '{wr: 8'h00, rd: 1'b1, ev: 1'b0, ef: 1'b0, eov: 1'b0, eo: 1'b1};
    tbl[5] = '{wr: 8'h00, rd: 1'b0, ev: 1'b0, ef: 1'b0, eov: 1'b0, eo: 1'b0};
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].wr, lane_c, tbl[i].rd, 1'b0);
      check($sformatf("tbl%0d_valid", i), {127'b0, o_valid}, {127'b0, tbl[i].ev});
      check($sformatf("tbl%0d_full", i), {127'b0, o_full}, {127'b0, tbl[i].ef});
      check($sformatf("tbl%0d_ovf", i), {127'b0, o_overflow}, {127'b0, tbl[i].eov});
      check($sformatf("tbl%0d_outv", i), {127'b0, o_out_valid}, {127'b0, tbl[i].eo});
    end
    check("row_c", out, lane_c);

    // Skew: fill lane 0 alone, overflow it, then catch up the other lanes and drain.
    for (int k = 0; k < Depth; k++) cyc(8'h01, fill(16'(k)), 1'b0, 1'b0);
    check("skew_full", {127'b0, o_full}, 128'd1);
    cyc(8'h01, fill(16'hDEAD), 1'b0, 1'b0);
    check("skew_ovf", {127'b0, o_overflow}, 128'd1);
    for (int k = 0; k < Depth; k++) cyc(8'hFE, fill(16'(k)), 1'b0, 1'b0);
    rows_out = 0;
    for (int k = 0; k < Depth; k++) cyc('0, '0, 1'b1, 1'b0);
    check("skew_rows", 128'(rows_out), 128'(Depth));
    check("skew_last", out, fill(16'(Depth - 1)));

    // Wrap-around streaming: 40 rows, read as soon as the model says a row is ready.
    cyc('0, '0, 1'b0, 1'b1);
    rows_out = 0;
    for (int k = 0; k < 40; k++) cyc(8'hFF, fill(16'(k)), m_valid(), 1'b0);
    guard = 0;
    while (m_valid() && guard < 50) begin
      cyc('0, '0, 1'b1, 1'b0);
      guard++;
    end
    check("wrap_rows", 128'(rows_out), 128'd40);
    check("wrap_last", out, fill(16'd39));

    // Simultaneous read and write with one row stored.
    cyc('0, '0, 1'b0, 1'b1);
    cyc(8'hFF, fill(16'h1111), 1'b0, 1'b0);
    cyc(8'hFF, fill(16'hAAAA), 1'b1, 1'b0);
    check("sim_row0", out, fill(16'h1111));
    check("sim_valid", {127'b0, o_valid}, 128'd1);
    cyc('0, '0, 1'b1, 1'b0);
    check("sim_row1", out, fill(16'hAAAA));

    // Reset takes priority over a same-cycle read with rows stored.
    for (int k = 0; k < 5; k++) cyc(8'hFF, fill(16'h0500 + 16'(k)), 1'b0, 1'b0);
    cyc('0, '0, 1'b1, 1'b1);
    check("rst_out", out, '0);
    check("rst_outv", {127'b0, o_out_valid}, 128'd0);
    check("rst_valid", {127'b0, o_valid}, 128'd0);
    cyc(8'hFF, fill(16'h5555), 1'b0, 1'b0);
    cyc('0, '0, 1'b1, 1'b0);
    check("rst_new", out, fill(16'h5555));
    cyc('0, '0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
